seven_segment_scanner: RTL

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner
// Description : Time-multiplexed driver for NUM_DIGITS seven-segment digits.
//               A prescaler paces the digit scan; new display data is staged
//               in a pending register and only becomes visible at a frame
//               boundary, so a frame never shows a mix of old and new digits.
//               Optional leading-zero blanking and global display enable.
// Ports       : clk                - sole clock, rising edge
//               reset              - asynchronous, active-high reset
//               value              - hex nibbles, digit k = value[4k+3:4k]
//               valueValid         - single-cycle load strobe
//               decimalPoints      - bit k lights the dp of digit k
//               displayEnable      - 0 blanks the display
//               suppressZeros      - 1 enables leading-zero blanking
//               sevenSegmentData   - registered segments {dp,g,f,e,d,c,b,a}
//               sevenSegmentEnable - registered one-hot digit select
//               frameDone          - registered pulse after each frame boundary
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      valueValid,
    input  logic [NUM_DIGITS-1:0]     decimalPoints,
    input  logic                      displayEnable,
    input  logic                      suppressZeros,
    output logic [7:0]                sevenSegmentData,
    output logic [NUM_DIGITS-1:0]     sevenSegmentEnable,
    output logic                      frameDone
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] c_presc_last = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] c_digit_last = IW'(NUM_DIGITS - 1);
    localparam logic          c_seg_pol    = (SEG_ACTIVE_LOW != 0);
    localparam logic          c_en_pol     = (EN_ACTIVE_LOW != 0);
    localparam logic [7:0]    c_seg_blank  = {8{c_seg_pol}};
    localparam logic [NUM_DIGITS-1:0] c_en_blank = {NUM_DIGITS{c_en_pol}};

    // State
    logic [PW-1:0]           prescaler_q, prescaler_d;
    logic [IW-1:0]           index_q, index_d;
    logic [4*NUM_DIGITS-1:0] active_value_q, active_value_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [4*NUM_DIGITS-1:0] pending_value_q, pending_value_d;
    logic [NUM_DIGITS-1:0]   pending_dp_q, pending_dp_d;
    logic                    pending_flag_q, pending_flag_d;
    logic                    frame_done_q, frame_done_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;

    // Combinational intermediates
    logic                    w_tick;
    logic                    w_boundary;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic [6:0]              w_glyph;
    logic [IW-1:0]           w_msd;
    logic                    w_suppress;
    logic [7:0]              w_seg_logical;
    logic [NUM_DIGITS-1:0]   w_en_logical;

    always_comb begin
        // Scan timing
        w_tick      = (prescaler_q == c_presc_last);
        w_boundary  = w_tick && (index_q == c_digit_last);
        prescaler_d = w_tick ? '0 : prescaler_q + PW'(1);
        index_d     = index_q;
        if (w_tick) begin
            index_d = (index_q == c_digit_last) ? '0 : index_q + IW'(1);
        end
        frame_done_d = w_boundary;

        // Double-buffered display data. A strobe landing exactly on the
        // boundary bypasses pending so it is not delayed by a whole frame.
        active_value_d  = active_value_q;
        active_dp_d     = active_dp_q;
        pending_value_d = pending_value_q;
        pending_dp_d    = pending_dp_q;
        pending_flag_d  = pending_flag_q;
        if (w_boundary && valueValid) begin
            active_value_d = value;
            active_dp_d    = decimalPoints;
            pending_flag_d = 1'b0;
        end else begin
            if (w_boundary && pending_flag_q) begin
                active_value_d = pending_value_q;
                active_dp_d    = pending_dp_q;
                pending_flag_d = 1'b0;
            end
            if (valueValid) begin
                pending_value_d = value;
                pending_dp_d    = decimalPoints;
                pending_flag_d  = 1'b1;
            end
        end

        // Most significant nonzero digit; stays 0 for an all-zero value so
        // digit 0 is never blanked.
        w_msd = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (active_value_q[4*k +: 4] != 4'h0) begin
                w_msd = IW'(k);
            end
        end
        w_suppress = suppressZeros && (index_q > w_msd);

        // Glyph lookup, logical polarity, gfedcba
        w_nibble = active_value_q[4*index_q +: 4];
        w_dp     = active_dp_q[index_q];
        case (w_nibble)
            4'h0:    w_glyph = 7'h3F;
            4'h1:    w_glyph = 7'h06;
            4'h2:    w_glyph = 7'h5B;
            4'h3:    w_glyph = 7'h4F;
            4'h4:    w_glyph = 7'h66;
            4'h5:    w_glyph = 7'h6D;
            4'h6:    w_glyph = 7'h7D;
            4'h7:    w_glyph = 7'h07;
            4'h8:    w_glyph = 7'h7F;
            4'h9:    w_glyph = 7'h6F;
            4'hA:    w_glyph = 7'h77;
            4'hB:    w_glyph = 7'h7C;
            4'hC:    w_glyph = 7'h39;
            4'hD:    w_glyph = 7'h5E;
            4'hE:    w_glyph = 7'h79;
            default: w_glyph = 7'h71;
        endcase

        w_seg_logical = 8'h00;
        w_en_logical  = '0;
        if (displayEnable) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                w_en_logical[k] = (index_q == IW'(k));
            end
            if (!w_suppress) begin
                w_seg_logical = {w_dp, w_glyph};
            end
        end

        // Polarity is applied as the very last step
        seg_d = w_seg_logical ^ c_seg_blank;
        en_d  = w_en_logical ^ c_en_blank;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q     <= '0;
            index_q         <= '0;
            active_value_q  <= '0;
            active_dp_q     <= '0;
            pending_value_q <= '0;
            pending_dp_q    <= '0;
            pending_flag_q  <= 1'b0;
            frame_done_q    <= 1'b0;
            seg_q           <= c_seg_blank;
            en_q            <= c_en_blank;
        end else begin
            prescaler_q     <= prescaler_d;
            index_q         <= index_d;
            active_value_q  <= active_value_d;
            active_dp_q     <= active_dp_d;
            pending_value_q <= pending_value_d;
            pending_dp_q    <= pending_dp_d;
            pending_flag_q  <= pending_flag_d;
            frame_done_q    <= frame_done_d;
            seg_q           <= seg_d;
            en_q            <= en_d;
        end
    end

    assign sevenSegmentData   = seg_q;
    assign sevenSegmentEnable = en_q;
    assign frameDone          = frame_done_q;

endmodule
`default_nettype wire
